// File: rtl/alu_issue_stage.sv
// alu_issue_stage: buffers ALU requests in a small FIFO, issues them one at a
// time to an external combinational ALU from registers, and captures each
// result into a response register handed downstream with valid/ready.
module alu_issue_stage #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [WIDTH-1:0]         req_a,
  input  logic [WIDTH-1:0]         req_b,
  input  logic [SEL_W-1:0]         req_sel,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [SEL_W-1:0]         alu_sel,
  input  logic [WIDTH-1:0]         alu_out,
  input  logic                     alu_carry,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_result,
  output logic                     rsp_carry,
  output logic [SEL_W-1:0]         rsp_sel,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] mem_a   [DEPTH];
  logic [WIDTH-1:0] mem_b   [DEPTH];
  logic [SEL_W-1:0] mem_sel [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  logic push;
  logic pop;
  logic load_rsp;
  logic rsp_fire;
  logic fifo_nonempty;

  // Full FIFO refuses a push even if the FSM pops in the same cycle (no bypass).
  assign req_ready     = (count != FULL_COUNT);
  assign push          = req_valid & req_ready;
  assign rsp_fire      = rsp_valid & rsp_ready;
  assign fifo_nonempty = (count != '0);
  assign busy          = (state != IDLE) | fifo_nonempty;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state: one EXEC cycle per op, then wait in RESP for the handshake.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fifo_nonempty) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_fire) state_next = fifo_nonempty ? EXEC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: when to pop the FIFO head and when to capture the ALU result.
  always_comb begin
    pop      = 1'b0;
    load_rsp = 1'b0;
    case (state)
      IDLE:    pop = fifo_nonempty;
      EXEC:    load_rsp = 1'b1;
      RESP:    pop = rsp_fire & fifo_nonempty;
      default: ;
    endcase
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr]   <= req_a;
      mem_b[wr_ptr]   <= req_b;
      mem_sel[wr_ptr] <= req_sel;
    end
  end

  // FIFO pointers wrap naturally at DEPTH; count tracks push/pop balance.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Operand registers feeding the ALU; they hold the last op until the next pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= '0;
    end else if (pop) begin
      alu_a   <= mem_a[rd_ptr];
      alu_b   <= mem_b[rd_ptr];
      alu_sel <= mem_sel[rd_ptr];
    end
  end

  // Response register: capture after the ALU has settled for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_sel    <= '0;
    end else if (load_rsp) begin
      rsp_valid  <= 1'b1;
      rsp_result <= alu_out;
      rsp_carry  <= alu_carry;
      rsp_sel    <= alu_sel;
    end else if (rsp_fire) begin
      rsp_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: drives alu_issue_stage with directed and random traffic,
// closes the loop with a behavioural ALU, and compares every cycle against a
// queue-based model of the issue pipeline.
module tb_alu_issue_stage;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic [3:0] req_sel;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_sel;
  logic [7:0] alu_out;
  logic       alu_carry;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result;
  logic       rsp_carry;
  logic [3:0] rsp_sel;
  logic       busy;
  logic [2:0] count;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] sel;
  } op_t;

  int checkCount = 0;
  int failCount  = 0;
  int cycleNo    = 0;

  op_t fifoQ[$];
  op_t stimQ[$];
  op_t lastOp;
  bit  stageBusy;
  bit  stageResp;
  bit  lastPushed;
  logic [7:0] expResult;
  logic       expCarry;
  logic [3:0] expSel;

  logic [3:0] respSels[$];
  int         respCycles[$];

  alu_issue_stage #(.WIDTH(8), .SEL_W(4), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_sel    (req_sel),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_out    (alu_out),
    .alu_carry  (alu_carry),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_sel    (rsp_sel),
    .busy       (busy),
    .count      (count)
  );

  // Behavioural ALU: 1 = add with carry, 2 = subtract with borrow, 0 = pass A, else XOR.
  function automatic logic [8:0] aluRef(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
    case (sel)
      4'd0:    return {1'b0, a};
      4'd1:    return {1'b0, a} + {1'b0, b};
      4'd2:    return {1'b0, a} - {1'b0, b};
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  assign {alu_carry, alu_out} = aluRef(alu_a, alu_b, alu_sel);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cycleNo);
    end
  endtask

  task automatic applyStimulus(input bit valid, input logic [7:0] a, input logic [7:0] b,
                               input logic [3:0] sel, input bit ready, input bit rstVal);
    req_valid = valid;
    req_a     = a;
    req_b     = b;
    req_sel   = sel;
    rsp_ready = ready;
    rst       = rstVal;
  endtask

  // Advance the model across one clock edge using the inputs the DUT saw.
  task automatic modelEdge();
    int  sizePre;
    bit  fire;
    bit  take;
    sizePre    = fifoQ.size();
    fire       = stageResp && rsp_ready;
    take       = 1'b0;
    lastPushed = 1'b0;
    if (rst) begin
      fifoQ.delete();
      stageBusy = 1'b0;
      stageResp = 1'b0;
      lastOp    = '0;
      expResult = '0;
      expCarry  = 1'b0;
      expSel    = '0;
      return;
    end
    if (!stageBusy) begin
      if (sizePre > 0) take = 1'b1;
    end else if (!stageResp) begin
      stageResp = 1'b1;
      {expCarry, expResult} = aluRef(lastOp.a, lastOp.b, lastOp.sel);
      expSel = lastOp.sel;
    end else if (fire) begin
      stageResp = 1'b0;
      if (sizePre > 0) take = 1'b1;
      else             stageBusy = 1'b0;
    end
    if (take) begin
      lastOp    = fifoQ.pop_front();
      stageBusy = 1'b1;
      stageResp = 1'b0;
    end
    if (req_valid && sizePre != 4) begin
      fifoQ.push_back('{a: req_a, b: req_b, sel: req_sel});
      lastPushed = 1'b1;
    end
  endtask

  task automatic compareAll();
    checkOutput("count",      {29'd0, count},   fifoQ.size());
    checkOutput("req_ready",  req_ready,        fifoQ.size() != 4);
    checkOutput("busy",       busy,             stageBusy || fifoQ.size() != 0);
    checkOutput("rsp_valid",  rsp_valid,        stageResp);
    checkOutput("alu_a",      alu_a,            lastOp.a);
    checkOutput("alu_b",      alu_b,            lastOp.b);
    checkOutput("alu_sel",    alu_sel,          lastOp.sel);
    checkOutput("rsp_result", rsp_result,       expResult);
    checkOutput("rsp_carry",  rsp_carry,        expCarry);
    checkOutput("rsp_sel",    rsp_sel,          expSel);
  endtask

  task automatic tick();
    if (rsp_valid && rsp_ready) begin
      respSels.push_back(rsp_sel);
      respCycles.push_back(cycleNo);
    end
    @(posedge clk);
    modelEdge();
    #1;
    cycleNo++;
    compareAll();
  endtask

  // Present the head of stimQ each cycle; it leaves the queue once accepted.
  task automatic runCycles(input int n, input int readyPct);
    for (int i = 0; i < n; i++) begin
      if (stimQ.size() != 0)
        applyStimulus(1'b1, stimQ[0].a, stimQ[0].b, stimQ[0].sel, $urandom_range(99) < readyPct, 1'b0);
      else
        applyStimulus(1'b0, 8'($urandom), 8'($urandom), 4'($urandom), $urandom_range(99) < readyPct, 1'b0);
      tick();
      if (lastPushed) void'(stimQ.pop_front());
    end
  endtask

  initial begin
    bit reached;
    applyStimulus(1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b1);
    tick();
    tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 4'h0, 1'b1, 1'b0);
    tick();
    checkOutput("reset_req_ready", req_ready, 1);
    checkOutput("reset_count", {29'd0, count}, 0);

    // Single add: latency from push to operands and to response.
    applyStimulus(1'b1, 8'h0A, 8'h02, 4'd1, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 4'd0, 1'b1, 1'b0);
    tick();
    checkOutput("t1_alu_a", alu_a, 8'h0A);
    tick();
    checkOutput("t1_rsp_valid", rsp_valid, 1);
    checkOutput("t1_rsp_result", rsp_result, 8'h0C);
    checkOutput("t1_rsp_carry", rsp_carry, 0);
    checkOutput("t1_rsp_sel", rsp_sel, 1);
    tick();

    // Add that overflows into the carry.
    applyStimulus(1'b1, 8'hFF, 8'h01, 4'd1, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 4'd0, 1'b1, 1'b0);
    tick();
    tick();
    checkOutput("t2_rsp_result", rsp_result, 8'h00);
    checkOutput("t2_rsp_carry", rsp_carry, 1);
    tick();

    // Backpressure: six ops against a stalled consumer, then release.
    respSels.delete();
    for (int i = 1; i <= 6; i++) stimQ.push_back('{a: 8'(i * 16), b: 8'(i), sel: 4'(i)});
    runCycles(10, 0);
    checkOutput("t3_count_full", {29'd0, count}, 4);
    checkOutput("t3_req_ready", req_ready, 0);
    checkOutput("t3_rsp_sel_held", rsp_sel, 1);
    runCycles(30, 100);
    checkOutput("t3_all_pushed", stimQ.size(), 0);
    checkOutput("t3_resp_count", respSels.size(), 6);
    for (int i = 0; i < respSels.size() && i < 6; i++)
      checkOutput("t3_resp_order", respSels[i], i + 1);

    // Back-to-back sweep of every select value.
    respSels.delete();
    respCycles.delete();
    for (int i = 0; i < 16; i++) stimQ.push_back('{a: 8'($urandom), b: 8'($urandom), sel: 4'(i)});
    runCycles(50, 100);
    checkOutput("t4_resp_count", respSels.size(), 16);
    for (int i = 0; i < respSels.size() && i < 16; i++) begin
      checkOutput("t4_resp_sel", respSels[i], i);
      if (i > 0) checkOutput("t4_resp_spacing", respCycles[i] - respCycles[i-1], 2);
    end

    // Push and pop in the same cycle at count 2.
    for (int i = 0; i < 3; i++) stimQ.push_back('{a: 8'($urandom), b: 8'($urandom), sel: 4'd1});
    runCycles(6, 0);
    checkOutput("t5_count_pre", {29'd0, count}, 2);
    stimQ.push_back('{a: 8'h33, b: 8'h44, sel: 4'd2});
    runCycles(1, 100);
    checkOutput("t5_count_hold", {29'd0, count}, 2);
    runCycles(20, 100);

    // Reset while an op is executing with three more queued.
    for (int i = 0; i < 10; i++) stimQ.push_back('{a: 8'($urandom), b: 8'($urandom), sel: 4'($urandom)});
    reached = 1'b0;
    for (int i = 0; i < 30 && !reached; i++) begin
      runCycles(1, 100);
      if (stageBusy && !stageResp && fifoQ.size() == 3) reached = 1'b1;
    end
    checkOutput("t6_reached_exec_with_3", reached, 1);
    applyStimulus(1'b0, 8'h00, 8'h00, 4'h0, 1'b1, 1'b1);
    stimQ.delete();
    tick();
    checkOutput("t6_count", {29'd0, count}, 0);
    checkOutput("t6_req_ready", req_ready, 1);
    checkOutput("t6_rsp_valid", rsp_valid, 0);
    checkOutput("t6_alu_a", alu_a, 0);
    checkOutput("t6_busy", busy, 0);
    respSels.delete();
    runCycles(5, 100);
    checkOutput("t6_no_response", respSels.size(), 0);

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      if (stimQ.size() < 2 && $urandom_range(9) < 7)
        stimQ.push_back('{a: 8'($urandom), b: 8'($urandom), sel: 4'($urandom)});
      runCycles(1, 60);
    end
    runCycles(40, 100);
    checkOutput("rand_drained", {29'd0, count}, 0);
    checkOutput("rand_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
